// File: rtl/ref_force_wb_collector.sv
// rtl/ref_force_wb_collector.sv - buffers per-lane accumulated forces and serialises them round-robin to one writeback port
// Optional FORCE_WB_ZERO_FILTER_EN: discard pushes whose three force components are all +/-0.0.
module ref_force_wb_collector #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
  parameter int NUM_ACC           = 7,
  parameter int LANE_DEPTH        = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_ACC-1:0]               in_acc_valid,
  input  logic [NUM_ACC*ID_WIDTH-1:0]      in_acc_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_x,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_y,
  input  logic [NUM_ACC*DATA_WIDTH-1:0]    in_acc_force_z,
  input  logic [NUM_ACC-1:0]               in_start_wb,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ID_WIDTH-1:0]              wb_id,
  output logic [DATA_WIDTH-1:0]            wb_force_x,
  output logic [DATA_WIDTH-1:0]            wb_force_y,
  output logic [DATA_WIDTH-1:0]            wb_force_z,
  output logic [2:0]                       wb_lane,
  output logic                             wb_busy,
  output logic                             wb_done,
  output logic                             overflow
);

  localparam int ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;
  localparam int PTR_W   = $clog2(LANE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LANE_W  = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_DONE} state_t;

  logic [ENTRY_W-1:0] mem_q    [NUM_ACC][LANE_DEPTH];
  logic [ENTRY_W-1:0] mem_d    [NUM_ACC][LANE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_ACC];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_ACC];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_ACC];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_ACC];
  logic [CNT_W-1:0]   cnt_q    [NUM_ACC];
  logic [CNT_W-1:0]   cnt_d    [NUM_ACC];

  logic [LANE_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic               slot_valid_q, slot_valid_d;
  logic [ENTRY_W-1:0] slot_data_q, slot_data_d;
  logic [LANE_W-1:0]  slot_lane_q, slot_lane_d;
  logic               overflow_q, overflow_d;
  state_t             state_q, state_d;

  logic [ENTRY_W-1:0] entry_in [NUM_ACC];
  logic [NUM_ACC-1:0] push_req, push_acc, pop, drop, lane_nonempty;
  logic               load, grant_vld;
  logic [LANE_W-1:0]  grant_lane, cand;

  always_comb begin
    for (int k = 0; k < NUM_ACC; k++) begin
      entry_in[k] = {in_acc_id[k*ID_WIDTH +: ID_WIDTH],
                     in_acc_force_x[k*DATA_WIDTH +: DATA_WIDTH],
                     in_acc_force_y[k*DATA_WIDTH +: DATA_WIDTH],
                     in_acc_force_z[k*DATA_WIDTH +: DATA_WIDTH]};
`ifdef FORCE_WB_ZERO_FILTER_EN
      // Sign bit ignored so that -0.0 is filtered as well as +0.0.
      push_req[k] = in_acc_valid[k] &&
                    !((in_acc_force_x[k*DATA_WIDTH +: DATA_WIDTH-1] == '0) &&
                      (in_acc_force_y[k*DATA_WIDTH +: DATA_WIDTH-1] == '0) &&
                      (in_acc_force_z[k*DATA_WIDTH +: DATA_WIDTH-1] == '0));
`else
      push_req[k] = in_acc_valid[k];
`endif
      lane_nonempty[k] = (cnt_q[k] != '0);
    end
  end

  assign load = !slot_valid_q || wb_ready;

  // Round-robin search starts at rr_ptr_q, which holds (last grant + 1).
  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = '0;
    cand       = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      cand = LANE_W'((int'(rr_ptr_q) + i) % NUM_ACC);
      if (!grant_vld && lane_nonempty[cand]) begin
        grant_vld  = 1'b1;
        grant_lane = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_vld) pop[grant_lane] = 1'b1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_acc = '0;
    drop     = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      // A full lane still accepts when its head leaves in the same cycle.
      push_acc[k] = push_req[k] && ((cnt_q[k] != CNT_W'(LANE_DEPTH)) || pop[k]);
      drop[k]     = push_req[k] && !push_acc[k];
      if (push_acc[k]) begin
        mem_d[k][wr_ptr_q[k]] = entry_in[k];
        wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
      end
      if (pop[k]) rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
      cnt_d[k] = cnt_q[k] + CNT_W'(push_acc[k]) - CNT_W'(pop[k]);
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    slot_lane_d  = slot_lane_q;
    rr_ptr_d     = rr_ptr_q;
    overflow_d   = overflow_q | (|drop);
    if (load) begin
      slot_valid_d = grant_vld;
      if (grant_vld) begin
        slot_data_d = mem_q[grant_lane][rd_ptr_q[grant_lane]];
        slot_lane_d = grant_lane;
        rr_ptr_d    = (grant_lane == LANE_W'(NUM_ACC-1)) ? '0 : grant_lane + LANE_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wb_busy = 1'b0;
    wb_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|in_start_wb) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        wb_busy = 1'b1;
        if (!(|lane_nonempty) && !(|push_acc) && load) state_d = ST_DONE;
      end
      ST_DONE: begin
        wb_done = 1'b1;
        state_d = (|in_start_wb) ? ST_DRAIN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ACC; k++) begin
        for (int j = 0; j < LANE_DEPTH; j++) mem_q[k][j] <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      rr_ptr_q     <= '0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_lane_q  <= '0;
      overflow_q   <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_lane_q  <= slot_lane_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

  assign wb_valid = slot_valid_q;
  assign {wb_id, wb_force_x, wb_force_y, wb_force_z} = slot_data_q;
  assign wb_lane  = slot_lane_q;
  assign overflow = overflow_q;

endmodule
